// File: rtl/sim_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_mailbox_pkg
// Brief    : Shared constants and helpers for the simulation test mailbox:
//            register offsets, STATUS bit positions, watchdog fail code and
//            the byte-mask merge used by the read/write registers.
// Revision : 1.0 - initial release
// ============================================================================
package sim_mailbox_pkg;

    // Byte offsets of the mailbox registers; only bits [4:2] are decoded.
    localparam logic [4:0] OFS_TOHOST = 5'h00;
    localparam logic [4:0] OFS_STATUS = 5'h04;
    localparam logic [4:0] OFS_TXDATA = 5'h08;
    localparam logic [4:0] OFS_WDOG   = 5'h0C;
    localparam logic [4:0] OFS_CYCLE  = 5'h10;

    // STATUS register bit positions.
    localparam int unsigned STAT_DONE         = 0;
    localparam int unsigned STAT_PASS         = 1;
    localparam int unsigned STAT_WDOG_EXPIRED = 2;
    localparam int unsigned STAT_FIFO_FULL    = 3;
    localparam int unsigned STAT_FIFO_EMPTY   = 4;

    // Test number reported when the watchdog ends the test.
    localparam logic [15:0] WDOG_FAIL_NUM = 16'hFFFF;

    // Replace the bytes of old_val selected by mask with those of new_val.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  mask
    );
        logic [31:0] w_res;
        w_res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                w_res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_mailbox_con_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sim_mailbox_con_fifo
// Brief    : Register-based synchronous FIFO for console bytes. Fullness is
//            judged on the count at the start of the cycle, so a push into a
//            full FIFO is rejected even when a pop happens in the same cycle.
//            The head entry is presented from a register.
// Revision : 1.0 - initial release
// ============================================================================
module sim_mailbox_con_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned        c_ptr_w    = $clog2(DEPTH);
    localparam int unsigned        c_cnt_w    = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one_cnt  = c_cnt_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_head;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full       = (r_count == c_full_cnt);
    assign o_empty      = (r_count == '0);
    assign w_push_ok    = i_push && !o_full;
    assign w_pop_ok     = i_pop && !o_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;
    assign o_pop_data   = r_head;

    // Storage array: written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_count <= r_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop_ok);
            // Head follows the next entry on a pop, or the new byte when it
            // lands in an empty (or just emptied) FIFO.
            if (w_pop_ok) begin
                if (r_count == c_one_cnt) begin
                    if (w_push_ok) begin
                        r_head <= i_push_data;
                    end
                end else begin
                    r_head <= r_mem[w_rd_ptr_nxt];
                end
            end else if (w_push_ok && o_empty) begin
                r_head <= i_push_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sim_test_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : sim_test_mailbox
// Brief    : ICB slave through which firmware reports test completion
//            (riscv-tests TOHOST convention), with a console byte FIFO, a
//            watchdog that fails a hung test and a cycle counter that
//            freezes once the test is done.
// Revision : 1.0 - initial release
// ============================================================================
module sim_test_mailbox
    import sim_mailbox_pkg::*;
#(
    parameter int unsigned TX_FIFO_DEPTH = 8,
    parameter logic [31:0] WDOG_DEFAULT  = 32'd0,
    parameter int          SIM_DELAY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_icb_cmd_addr,
    input  logic        s_icb_cmd_read,
    input  logic [31:0] s_icb_cmd_wdata,
    input  logic [3:0]  s_icb_cmd_wmask,
    input  logic        s_icb_cmd_valid,
    output logic        s_icb_cmd_ready,
    output logic [31:0] s_icb_rsp_rdata,
    output logic        s_icb_rsp_err,
    output logic        s_icb_rsp_valid,
    input  logic        s_icb_rsp_ready,
    output logic        test_done,
    output logic        test_pass,
    output logic [15:0] test_num,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready
);

    // Reject unsupported configurations at elaboration time.
    if (!(TX_FIFO_DEPTH == 2 || TX_FIFO_DEPTH == 4 || TX_FIFO_DEPTH == 8 ||
          TX_FIFO_DEPTH == 16) || SIM_DELAY < 0) begin : g_bad_cfg
        $error("sim_test_mailbox: unsupported TX_FIFO_DEPTH or SIM_DELAY");
    end

    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_tohost;
    logic [31:0] r_wdog;
    logic [31:0] r_cycle;
    logic        r_done;
    logic        r_pass;
    logic        r_expired;
    logic [15:0] r_num;

    logic        w_accept;
    logic        w_wr;
    logic [4:0]  w_ofs;
    logic        w_sel_tohost;
    logic        w_sel_status;
    logic        w_sel_txdata;
    logic        w_sel_wdog;
    logic        w_sel_cycle;
    logic [31:0] w_tohost_merged;
    logic [31:0] w_wdog_merged;
    logic        w_result_wr;
    logic        w_wdog_wr;
    logic        w_wdog_expire;
    logic        w_push;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_err;
    logic        w_unused_addr_bits;

    // Address bits outside the register window are ignored.
    assign w_unused_addr_bits = ^{s_icb_cmd_addr[31:5], s_icb_cmd_addr[1:0]};

    assign s_icb_cmd_ready = !r_rsp_valid || s_icb_rsp_ready;
    assign w_accept        = s_icb_cmd_valid && s_icb_cmd_ready;
    assign w_wr            = w_accept && !s_icb_cmd_read;
    assign w_ofs           = {s_icb_cmd_addr[4:2], 2'b00};

    assign w_sel_tohost = (w_ofs == OFS_TOHOST);
    assign w_sel_status = (w_ofs == OFS_STATUS);
    assign w_sel_txdata = (w_ofs == OFS_TXDATA);
    assign w_sel_wdog   = (w_ofs == OFS_WDOG);
    assign w_sel_cycle  = (w_ofs == OFS_CYCLE);

    assign w_tohost_merged = merge_bytes(r_tohost, s_icb_cmd_wdata, s_icb_cmd_wmask);
    assign w_wdog_merged   = merge_bytes(r_wdog, s_icb_cmd_wdata, s_icb_cmd_wmask);

    // Only the first result write (bit0 set) decides the outcome.
    assign w_result_wr = w_wr && w_sel_tohost && w_tohost_merged[0] && !r_done;
    assign w_wdog_wr   = w_wr && w_sel_wdog;
    // A reload in the expiry cycle cancels it; a same-cycle result beats it.
    assign w_wdog_expire = !w_wdog_wr && !r_done && (r_wdog == 32'd1) && !w_result_wr;
    assign w_push        = w_wr && w_sel_txdata && s_icb_cmd_wmask[0];

    // STATUS word assembled from the live flags.
    always_comb begin
        w_status                    = '0;
        w_status[STAT_DONE]         = r_done;
        w_status[STAT_PASS]         = r_pass;
        w_status[STAT_WDOG_EXPIRED] = r_expired;
        w_status[STAT_FIFO_FULL]    = w_fifo_full;
        w_status[STAT_FIFO_EMPTY]   = w_fifo_empty;
    end

    // Read data and error for the command being accepted this cycle.
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_sel_tohost) begin
            if (s_icb_cmd_read) w_rdata = r_tohost;
        end else if (w_sel_status) begin
            if (s_icb_cmd_read) w_rdata = w_status;
            else                w_err   = 1'b1;
        end else if (w_sel_txdata) begin
            if (!s_icb_cmd_read && s_icb_cmd_wmask[0] && w_fifo_full) w_err = 1'b1;
        end else if (w_sel_wdog) begin
            if (s_icb_cmd_read) w_rdata = r_wdog;
        end else if (w_sel_cycle) begin
            if (s_icb_cmd_read) w_rdata = r_cycle;
            else                w_err   = 1'b1;
        end else begin
            w_err = 1'b1;
        end
    end

    // Response channel: one outstanding response, held until rsp_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_err;
        end else if (s_icb_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // TOHOST storage, test result, watchdog and cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tohost  <= '0;
            r_wdog    <= WDOG_DEFAULT;
            r_cycle   <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_expired <= 1'b0;
            r_num     <= '0;
        end else begin
            if (w_wr && w_sel_tohost) begin
                r_tohost <= w_tohost_merged;
            end
            if (w_wdog_wr) begin
                r_wdog <= w_wdog_merged;
            end else if (!r_done && (r_wdog != 32'd0)) begin
                r_wdog <= r_wdog - 32'd1;
            end
            if (!r_done) begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_result_wr) begin
                r_done <= 1'b1;
                r_pass <= (w_tohost_merged == 32'd1);
                r_num  <= w_tohost_merged[16:1];
            end else if (w_wdog_expire) begin
                r_done    <= 1'b1;
                r_pass    <= 1'b0;
                r_num     <= WDOG_FAIL_NUM;
                r_expired <= 1'b1;
            end
        end
    end

    sim_mailbox_con_fifo #(
        .DEPTH (TX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_con_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (s_icb_cmd_wdata[7:0]),
        .i_pop       (con_ready),
        .o_pop_data  (con_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign s_icb_rsp_valid = r_rsp_valid;
    assign s_icb_rsp_rdata = r_rsp_rdata;
    assign s_icb_rsp_err   = r_rsp_err;
    assign test_done       = r_done;
    assign test_pass       = r_pass;
    assign test_num        = r_num;
    assign con_valid       = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_sim_test_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_test_mailbox
// Brief    : Self-checking bench for sim_test_mailbox. A behavioural model
//            predicts each response into a queue; a monitor compares the
//            DUT's responses, result outputs and console stream against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_test_mailbox;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_icb_cmd_addr;
    logic        s_icb_cmd_read;
    logic [31:0] s_icb_cmd_wdata;
    logic [3:0]  s_icb_cmd_wmask;
    logic        s_icb_cmd_valid;
    logic        s_icb_cmd_ready;
    logic [31:0] s_icb_rsp_rdata;
    logic        s_icb_rsp_err;
    logic        s_icb_rsp_valid;
    logic        s_icb_rsp_ready;
    logic        test_done;
    logic        test_pass;
    logic [15:0] test_num;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;

    sim_test_mailbox #(
        .TX_FIFO_DEPTH (DEPTH),
        .WDOG_DEFAULT  (32'd0),
        .SIM_DELAY     (1)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .s_icb_cmd_addr  (s_icb_cmd_addr),
        .s_icb_cmd_read  (s_icb_cmd_read),
        .s_icb_cmd_wdata (s_icb_cmd_wdata),
        .s_icb_cmd_wmask (s_icb_cmd_wmask),
        .s_icb_cmd_valid (s_icb_cmd_valid),
        .s_icb_cmd_ready (s_icb_cmd_ready),
        .s_icb_rsp_rdata (s_icb_rsp_rdata),
        .s_icb_rsp_err   (s_icb_rsp_err),
        .s_icb_rsp_valid (s_icb_rsp_valid),
        .s_icb_rsp_ready (s_icb_rsp_ready),
        .test_done       (test_done),
        .test_pass       (test_pass),
        .test_num        (test_num),
        .con_data        (con_data),
        .con_valid       (con_valid),
        .con_ready       (con_ready)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [7:0]  m_fifo[$];
    logic [7:0]  got[$];
    logic [31:0] m_tohost = '0;
    logic [31:0] m_wdog   = '0;
    logic [31:0] m_cycle  = '0;
    logic        m_done   = 1'b0;
    logic        m_pass   = 1'b0;
    logic        m_exp    = 1'b0;
    logic        m_pend   = 1'b0;
    logic [15:0] m_num    = '0;
    bit          mon_en   = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          con_rand = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] m);
        logic [31:0] keep;
        keep = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (new_v & keep) | (old_v & ~keep);
    endfunction

    function automatic logic [31:0] status_word();
        logic [31:0] s;
        s    = '0;
        s[0] = m_done;
        s[1] = m_pass;
        s[2] = m_exp;
        s[3] = (m_fifo.size() == DEPTH);
        s[4] = (m_fifo.size() == 0);
        return s;
    endfunction

    // Reference model: advances one clock, predicting what a command accepted
    // on this edge returns and how the mailbox state evolves.
    function automatic void model_step();
        logic old_done, accept, full0, push_byte, result_now, loaded;
        rsp_t r;
        if (rst) begin
            m_tohost = '0; m_wdog = '0; m_cycle = '0;
            m_done = 1'b0; m_pass = 1'b0; m_exp = 1'b0; m_num = '0; m_pend = 1'b0;
            m_fifo.delete();
            exp_q.delete();
            return;
        end
        old_done   = m_done;
        full0      = (m_fifo.size() == DEPTH);
        push_byte  = 1'b0;
        result_now = 1'b0;
        loaded     = 1'b0;
        accept     = s_icb_cmd_valid && (!m_pend || s_icb_rsp_ready);
        if (accept) begin
            r = '0;
            case (s_icb_cmd_addr[4:2])
                3'd0: begin
                    if (s_icb_cmd_read) r.rdata = m_tohost;
                    else begin
                        m_tohost = merge(m_tohost, s_icb_cmd_wdata, s_icb_cmd_wmask);
                        if (m_tohost[0] && !old_done) begin
                            m_done = 1'b1;
                            m_pass = (m_tohost == 32'd1);
                            m_num  = m_tohost[16:1];
                            result_now = 1'b1;
                        end
                    end
                end
                3'd1: if (s_icb_cmd_read) r.rdata = status_word(); else r.err = 1'b1;
                3'd2: if (!s_icb_cmd_read && s_icb_cmd_wmask[0]) begin
                    if (full0) r.err = 1'b1;
                    else       push_byte = 1'b1;
                end
                3'd3: begin
                    if (s_icb_cmd_read) r.rdata = m_wdog;
                    else begin
                        m_wdog = merge(m_wdog, s_icb_cmd_wdata, s_icb_cmd_wmask);
                        loaded = 1'b1;
                    end
                end
                3'd4: if (s_icb_cmd_read) r.rdata = m_cycle; else r.err = 1'b1;
                default: r.err = 1'b1;
            endcase
            exp_q.push_back(r);
            m_pend = 1'b1;
        end else if (s_icb_rsp_ready) begin
            m_pend = 1'b0;
        end
        if (con_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (push_byte) m_fifo.push_back(s_icb_cmd_wdata[7:0]);
        if (!loaded && !old_done && m_wdog != 32'd0) begin
            if (m_wdog == 32'd1 && !result_now) begin
                m_done = 1'b1; m_pass = 1'b0; m_num = 16'hFFFF; m_exp = 1'b1;
            end
            m_wdog = m_wdog - 32'd1;
        end
        if (!old_done) m_cycle = m_cycle + 32'd1;
    endfunction

    always @(posedge clk) model_step();

    // Random back-pressure on the response and console sides.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) s_icb_rsp_ready = 1'($urandom_range(0, 1));
        if (con_rand) con_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: compares presented outputs with the model mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cmd_ready", 32'(s_icb_cmd_ready), 32'(!m_pend || s_icb_rsp_ready));
            chk("rsp_valid", 32'(s_icb_rsp_valid), 32'(m_pend));
            if (s_icb_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(s_icb_rsp_valid), 32'd0);
                end else begin
                    chk("rsp_rdata", s_icb_rsp_rdata, exp_q[0].rdata);
                    chk("rsp_err", 32'(s_icb_rsp_err), 32'(exp_q[0].err));
                    if (s_icb_rsp_ready) void'(exp_q.pop_front());
                end
            end
            chk("test_done", 32'(test_done), 32'(m_done));
            chk("test_pass", 32'(test_pass), 32'(m_pass));
            chk("test_num", 32'(test_num), 32'(m_num));
            chk("con_valid", 32'(con_valid), 32'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) chk("con_data", 32'(con_data), 32'(m_fifo[0]));
            if (con_valid && con_ready) got.push_back(con_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm);
        int   n;
        logic acc;
        s_icb_cmd_valid = 1'b1;
        s_icb_cmd_read  = rd;
        s_icb_cmd_addr  = addr;
        s_icb_cmd_wdata = wd;
        s_icb_cmd_wmask = wm;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_icb_cmd_ready;
            step();
            n++;
        end
        chk("bus_accept", 32'(acc), 32'd1);
        s_icb_cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        s_icb_cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        int         n;
        rst = 1'b1;
        s_icb_cmd_valid = 1'b0; s_icb_cmd_read = 1'b0; s_icb_cmd_addr = '0;
        s_icb_cmd_wdata = '0; s_icb_cmd_wmask = '0;
        s_icb_rsp_ready = 1'b1; con_ready = 1'b0;
        step();
        mon_en = 1'b1;
        do_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_done", 32'(test_done), 32'd0);
        chk("rst_con_valid", 32'(con_valid), 32'd0);
        step();

        // Passing result.
        bus(1'b0, 32'h0, 32'h1, 4'hF);
        @(negedge clk);
        chk("pass_rsp_valid", 32'(s_icb_rsp_valid), 32'd1);
        chk("pass_rsp_err", 32'(s_icb_rsp_err), 32'd0);
        chk("pass_done", 32'(test_done), 32'd1);
        chk("pass_pass", 32'(test_pass), 32'd1);
        chk("pass_num", 32'(test_num), 32'd0);
        step();

        // Failing result; the later pass write must not override it.
        do_reset();
        bus(1'b0, 32'h0, 32'hB, 4'hF);
        bus(1'b0, 32'h0, 32'h1, 4'hF);
        bus(1'b1, 32'h4, 32'h0, 4'h0);
        @(negedge clk);
        chk("fail_status", s_icb_rsp_rdata, 32'h11);
        chk("fail_pass", 32'(test_pass), 32'd0);
        chk("fail_num", 32'(test_num), 32'd5);
        step();

        // Console FIFO overflow, then drain in order.
        do_reset();
        con_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = (i == 0) ? 8'h48 : (i == 1) ? 8'h69 : 8'(8'h30 + i - 2);
            bus(1'b0, 32'h8, {24'h0, b}, 4'h1);
        end
        @(negedge clk);
        chk("ovf_err", 32'(s_icb_rsp_err), 32'd1);
        step();
        bus(1'b1, 32'h4, 32'h0, 4'h0);
        @(negedge clk);
        chk("ovf_status_full", 32'(s_icb_rsp_rdata[3]), 32'd1);
        step();
        con_ready = 1'b1;
        repeat (12) step();
        con_ready = 1'b0;
        chk("con_count", 32'(got.size()), 32'd8);
        if (got.size() == 8) begin
            chk("con_first", 32'(got[0]), 32'h48);
            chk("con_second", 32'(got[1]), 32'h69);
            chk("con_last", 32'(got[7]), 32'h35);
        end

        // Watchdog expiry; cycle counter frozen afterwards.
        do_reset();
        bus(1'b0, 32'hC, 32'd5, 4'hF);
        n = 0;
        while (!test_done && n < 20) begin step(); n++; end
        @(negedge clk);
        chk("wdog_done", 32'(test_done), 32'd1);
        chk("wdog_pass", 32'(test_pass), 32'd0);
        chk("wdog_num", 32'(test_num), 32'hFFFF);
        step();
        bus(1'b1, 32'h4, 32'h0, 4'h0);
        @(negedge clk);
        chk("wdog_status_exp", 32'(s_icb_rsp_rdata[2]), 32'd1);
        step();
        bus(1'b1, 32'h10, 32'h0, 4'h0);
        repeat (4) step();
        bus(1'b1, 32'h10, 32'h0, 4'h0);
        step();

        // Response stall, then reset in the middle of it.
        do_reset();
        s_icb_rsp_ready = 1'b0;
        bus(1'b1, 32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_cmd_ready", 32'(s_icb_cmd_ready), 32'd0);
            chk("stall_rsp_valid", 32'(s_icb_rsp_valid), 32'd1);
            step();
        end
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("stall_rst_valid", 32'(s_icb_rsp_valid), 32'd0);
        chk("stall_rst_done", 32'(test_done), 32'd0);
        step();
        rst = 1'b0;
        s_icb_rsp_ready = 1'b1;

        // Unmapped read and write to read-only STATUS.
        do_reset();
        bus(1'b1, 32'h18, 32'h0, 4'h0);
        @(negedge clk);
        chk("unmapped_err", 32'(s_icb_rsp_err), 32'd1);
        chk("unmapped_rdata", s_icb_rsp_rdata, 32'd0);
        step();
        bus(1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        chk("ro_write_err", 32'(s_icb_rsp_err), 32'd1);
        step();
        bus(1'b1, 32'h4, 32'h0, 4'h0);
        step();

        // Randomized traffic against the model.
        do_reset();
        rdy_rand = 1'b1;
        con_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  idx;
            logic        rd;
            logic [31:0] wd;
            idx = 3'($urandom_range(0, 7));
            rd  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (idx == 3'd0) wd[0] = ($urandom_range(0, 15) == 0);
            if (idx == 3'd3) wd = 32'($urandom_range(0, 300));
            if ($urandom_range(0, 3) == 0) step();
            bus(rd, {27'h0, idx, 2'b00}, wd, 4'($urandom_range(0, 15)));
        end
        rdy_rand = 1'b0;
        con_rand = 1'b0;
        s_icb_rsp_ready = 1'b1;
        repeat (5) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
